mem_boot_arbiter: RTL and testbench

MEM_BOOT_ARBITER -- requirements
Module: mem_boot_arbiter

---
 rtl/mem_boot_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_boot_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_arbiter.sv
// Boot loader / memory arbiter: streams program words into byte memory, zero-fills the rest,
// then releases the processor and hands it the memory port.
module mem_boot_arbiter #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-2:0] WordCount,
    input  logic              LdValid,
    input  logic [31:0]       LdData,
    output logic              LdReady,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [7:0]        CpuWData,
    output logic              CpuGnt,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWData,
    output logic              CpuReset,
    output logic              Busy,
    output logic              Done
);

    localparam int CNT_W = ADDR_W - 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / 4);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, FILL, RELEASE, RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [CNT_W-1:0]    words_reg;
    logic [CNT_W-1:0]    target_reg;
    logic [31:0]         data_reg;
    logic                ld_ready_reg;
    logic                mem_wr_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [7:0]          mem_wdata_reg;
    logic                cpu_reset_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [CNT_W-1:0]    start_target;
    logic [7:0]          word_bytes [4];
    logic                run;

    assign start_target = (WordCount > MAX_WORDS) ? MAX_WORDS : WordCount;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign word_bytes[gi] = data_reg[8*gi +: 8];
    end

    // Words start on 4-byte boundaries, so ptr[1:0] doubles as the byte-lane index inside WRITE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            words_reg     <= '0;
            target_reg    <= '0;
            data_reg      <= '0;
            ld_ready_reg  <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_reset_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, RUN: begin
                    if (Start) begin
                        target_reg    <= start_target;
                        words_reg     <= '0;
                        cpu_reset_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        if (start_target == '0) begin
                            state_reg     <= FILL;
                            mem_wr_reg    <= 1'b1;
                            mem_addr_reg  <= '0;
                            mem_wdata_reg <= '0;
                            ptr_reg       <= ADDR_W'(1);
                        end else begin
                            state_reg    <= FETCH;
                            ld_ready_reg <= 1'b1;
                            ptr_reg      <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (LdValid) begin
                        state_reg     <= WRITE;
                        data_reg      <= LdData;
                        words_reg     <= words_reg + CNT_W'(1);
                        ld_ready_reg  <= 1'b0;
                        mem_wr_reg    <= 1'b1;
                        mem_addr_reg  <= ptr_reg;
                        mem_wdata_reg <= LdData[7:0];
                        ptr_reg       <= ptr_reg + ADDR_W'(1);
                    end
                end
                WRITE: begin
                    if (ptr_reg[1:0] != 2'd0) begin
                        mem_addr_reg  <= ptr_reg;
                        mem_wdata_reg <= word_bytes[ptr_reg[1:0]];
                        ptr_reg       <= ptr_reg + ADDR_W'(1);
                    end else if (words_reg != target_reg) begin
                        state_reg     <= FETCH;
                        ld_ready_reg  <= 1'b1;
                        mem_wr_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                    end else if (ptr_reg == '0) begin
                        state_reg     <= RELEASE;
                        mem_wr_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                    end else begin
                        state_reg     <= FILL;
                        mem_addr_reg  <= ptr_reg;
                        mem_wdata_reg <= '0;
                        ptr_reg       <= ptr_reg + ADDR_W'(1);
                    end
                end
                FILL: begin
                    // ptr wraps to 0 once the last address has been presented.
                    if (ptr_reg == '0) begin
                        state_reg    <= RELEASE;
                        mem_wr_reg   <= 1'b0;
                        mem_addr_reg <= '0;
                    end else begin
                        mem_addr_reg  <= ptr_reg;
                        mem_wdata_reg <= '0;
                        ptr_reg       <= ptr_reg + ADDR_W'(1);
                    end
                end
                RELEASE: begin
                    state_reg     <= RUN;
                    cpu_reset_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The processor path is combinational so a granted access lands in the same cycle.
    assign run      = (state_reg == RUN);
    assign CpuGnt   = run & CpuReq;
    assign MemEn    = run ? CpuReq : mem_wr_reg;
    assign MemWe    = run ? (CpuReq & CpuWe) : mem_wr_reg;
    assign MemAddr  = run ? CpuAddr : mem_addr_reg;
    assign MemWData = run ? CpuWData : mem_wdata_reg;
    assign LdReady  = ld_ready_reg;
    assign CpuReset = cpu_reset_reg;
    assign Busy     = busy_reg;
    assign Done     = done_reg;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Bench for mem_boot_arbiter: table-driven loads and RUN-port vectors, randomized loads
// checked against an address/byte image model, plus reset corner sequences.
module tb_mem_boot_arbiter;

    localparam int MEM_BYTES = 4096;
    localparam int ADDR_W    = 12;
    localparam int WORDS     = MEM_BYTES / 4;
    localparam int LIMIT     = 20000;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W-2:0] WordCount = '0;
    logic              LdValid = 1'b0;
    logic [31:0]       LdData = '0;
    logic              LdReady;
    logic              CpuReq = 1'b0;
    logic              CpuWe = 1'b0;
    logic [ADDR_W-1:0] CpuAddr = '0;
    logic [7:0]        CpuWData = '0;
    logic              CpuGnt;
    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemWData;
    logic              CpuReset;
    logic              Busy;
    logic              Done;

    int checks = 0;
    int failures = 0;

    mem_boot_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount),
        .LdValid(LdValid), .LdData(LdData), .LdReady(LdReady),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(CpuGnt), .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .CpuReset(CpuReset), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int wc;
        int stall_pct;
        int first_stall;
        bit fixed;
        int exp_data;
        int exp_fill;
    } load_vec_t;

    typedef struct {
        bit               req;
        bit               we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]       wdata;
        bit               en;
        bit               mwe;
        bit               gnt;
    } run_vec_t;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: bytes land little-endian at 4w..4w+3 for each loaded word, then zeros to the top.
    task automatic run_load(input int wc, input int stall_pct, input int first_stall, input bit fixed,
                            input int exp_data, input int exp_fill, input string name);
        logic [31:0] words[$];
        logic [19:0] exp_q[$];
        logic [19:0] got_q[$];
        int target, idx, cyc, viol, stall_left, stall_seen, stall_viol, last_wr, done_cyc, mism;
        logic [19:0] ga, ea;
        target = (wc > WORDS) ? WORDS : wc;
        for (int w = 0; w < target; w++) words.push_back($urandom);
        if (fixed && target >= 2) begin
            words[0] = 32'hDDCCBBAA;
            words[1] = 32'h44332211;
        end
        for (int w = 0; w < target; w++)
            for (int b = 0; b < 4; b++) exp_q.push_back({12'(4*w + b), words[w][8*b +: 8]});
        for (int a = 4*target; a < MEM_BYTES; a++) exp_q.push_back({12'(a), 8'h00});

        @(negedge Clk);
        Start = 1'b1; WordCount = wc[ADDR_W-2:0]; LdValid = 1'b0; CpuReq = 1'b1; CpuWe = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check(CpuReset && Busy && !Done && !CpuGnt, {name, "_entry"},
              {CpuReset, Busy, Done, CpuGnt}, 4'b1100);

        idx = 0; cyc = 0; viol = 0; stall_left = first_stall; stall_seen = 0; stall_viol = 0;
        last_wr = -1; done_cyc = -1;
        while (done_cyc < 0 && cyc < LIMIT) begin
            if (Done) begin
                done_cyc = cyc;
                Start = 1'b0;
                CpuReq = 1'b0;
            end else begin
                if (MemEn && MemWe) begin
                    got_q.push_back({MemAddr, MemWData});
                    last_wr = cyc;
                end
                if (MemEn != MemWe || CpuGnt || !CpuReset || !Busy || (LdReady && MemEn)) viol++;
                if (stall_left > 0 && stall_left < first_stall && !LdReady) stall_viol++;
                if (LdReady && stall_left > 0) begin
                    LdValid = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    LdValid = ($urandom_range(0, 99) >= stall_pct);
                end
                LdData = (idx < target) ? words[idx] : $urandom;
                if (LdValid && LdReady) idx++;
                Start = ($urandom_range(0, 39) == 0);
                WordCount = $urandom;
                CpuReq = $urandom;
                CpuWe = $urandom;
                CpuAddr = $urandom;
                CpuWData = $urandom;
                cyc++;
                @(negedge Clk);
            end
        end
        Start = 1'b0; LdValid = 1'b0;

        check(done_cyc >= 0, {name, "_timeout"}, 64'(cyc), 64'(LIMIT));
        check(got_q.size() == exp_data + exp_fill, {name, "_write_count"},
              64'(got_q.size()), 64'(exp_data + exp_fill));
        mism = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        if (mism < 0 && exp_q.size() != got_q.size())
            mism = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
        ga = (mism >= 0 && mism < got_q.size()) ? got_q[mism] : 20'hFFFFF;
        ea = (mism >= 0 && mism < exp_q.size()) ? exp_q[mism] : 20'hFFFFF;
        check(mism < 0, {name, "_write_seq"}, 64'(ga), 64'(ea));
        check(viol == 0, {name, "_load_invariants"}, 64'(viol), 64'd0);
        check(done_cyc - last_wr == 2, {name, "_release_gap"}, 64'(done_cyc - last_wr), 64'd2);
        check(!CpuReset && !Busy && !LdReady, {name, "_run_status"}, {CpuReset, Busy, LdReady}, 3'b000);
        if (first_stall > 0)
            check(stall_seen == first_stall && stall_viol == 0, {name, "_stall"},
                  64'(stall_viol), 64'd0);
        $display("load %s wc=%0d writes=%0d cycles=%0d", name, wc, got_q.size(), done_cyc);
    endtask

    task automatic run_port(input run_vec_t v, input string name);
        @(negedge Clk);
        CpuReq = v.req; CpuWe = v.we; CpuAddr = v.addr; CpuWData = v.wdata;
        #1;
        check({MemEn, MemWe, CpuGnt, MemAddr, MemWData} === {v.en, v.mwe, v.gnt, v.addr, v.wdata},
              name, {MemEn, MemWe, CpuGnt, MemAddr, MemWData}, {v.en, v.mwe, v.gnt, v.addr, v.wdata});
        $display("run %s req=%0d we=%0d addr=%h data=%h", name, v.req, v.we, v.addr, v.wdata);
    endtask

    load_vec_t loads[6];
    run_vec_t  rvecs[4];

    initial begin
        int bad, seen, wc;
        run_vec_t rv;

        loads[0] = '{2,    0,  0,  1'b1, 8,    4088};
        loads[1] = '{0,    0,  0,  1'b0, 0,    4096};
        loads[2] = '{1024, 0,  0,  1'b0, 4096, 0};
        loads[3] = '{2000, 0,  0,  1'b0, 4096, 0};
        loads[4] = '{3,    0,  10, 1'b0, 12,   4084};
        loads[5] = '{37,   30, 0,  1'b0, 148,  3948};
        rvecs[0] = '{1'b1, 1'b1, 12'h010, 8'h5A, 1'b1, 1'b1, 1'b1};
        rvecs[1] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 1'b0, 1'b1};
        rvecs[2] = '{1'b0, 1'b1, 12'h123, 8'hC3, 1'b0, 1'b0, 1'b0};
        rvecs[3] = '{1'b0, 1'b0, 12'h000, 8'hFF, 1'b0, 1'b0, 1'b0};

        // Reset state, with a processor request pending.
        CpuReq = 1'b1; CpuWe = 1'b1; Start = 1'b1;
        repeat (2) @(negedge Clk);
        check({CpuReset, LdReady, MemEn, MemWe, CpuGnt, Busy, Done} === 7'b1000000, "reset_ctrl",
              {CpuReset, LdReady, MemEn, MemWe, CpuGnt, Busy, Done}, 7'b1000000);
        check({MemAddr, MemWData} === 20'h0, "reset_bus", {MemAddr, MemWData}, 20'h0);
        Reset = 1'b0; Start = 1'b0; CpuReq = 1'b0;
        @(negedge Clk);
        check(!Busy && CpuReset, "idle_hold", {Busy, CpuReset}, 2'b01);

        for (int i = 0; i < 6; i++) begin
            run_load(loads[i].wc, loads[i].stall_pct, loads[i].first_stall, loads[i].fixed,
                     loads[i].exp_data, loads[i].exp_fill, $sformatf("vec%0d", i));
            if (i == 0)
                for (int j = 0; j < 4; j++) run_port(rvecs[j], $sformatf("port_vec%0d", j));
        end

        // Randomized processor accesses in RUN.
        for (int j = 0; j < 12; j++) begin
            rv.req = $urandom; rv.we = $urandom; rv.addr = $urandom; rv.wdata = $urandom;
            rv.en = rv.req; rv.mwe = rv.req & rv.we; rv.gnt = rv.req;
            run_port(rv, $sformatf("port_rand%0d", j));
        end

        // Reset in the middle of a WRITE burst.
        @(negedge Clk);
        Start = 1'b1; WordCount = 11'd4; CpuReq = 1'b1; CpuWe = 1'b1; LdValid = 1'b1;
        LdData = 32'hCAFEF00D;
        @(negedge Clk);
        Start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (MemWe) seen = 1;
            else @(negedge Clk);
        end
        check(seen == 1, "midwrite_reach", 64'(seen), 64'd1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check({CpuReset, LdReady, MemEn, MemWe, CpuGnt, Busy, Done} === 7'b1000000, "midwrite_reset_ctrl",
              {CpuReset, LdReady, MemEn, MemWe, CpuGnt, Busy, Done}, 7'b1000000);
        check({MemAddr, MemWData} === 20'h0, "midwrite_reset_bus", {MemAddr, MemWData}, 20'h0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (MemEn || MemWe || LdReady || Busy || Done || CpuGnt) bad++;
        end
        check(bad == 0, "midwrite_quiet", 64'(bad), 64'd0);
        LdValid = 1'b0;

        // A fresh load after the aborted one must start over at address 0.
        run_load(2, 0, 0, 1'b0, 8, 4088, "after_abort");

        // Start and Reset together: Reset wins, nothing resumes.
        @(negedge Clk);
        Start = 1'b1; Reset = 1'b1; WordCount = 11'd5;
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (Busy || LdReady || Done || !CpuReset || MemEn) bad++;
            @(negedge Clk);
        end
        check(bad == 0, "start_reset_priority", 64'(bad), 64'd0);

        for (int r = 0; r < 2; r++) begin
            wc = $urandom_range(0, 2047);
            run_load(wc, $urandom_range(0, 40), 0, 1'b0, 4 * ((wc > WORDS) ? WORDS : wc),
                     MEM_BYTES - 4 * ((wc > WORDS) ? WORDS : wc), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
